// File: rtl/fu_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module     : fu_alu_pipe
// Description: Pipelined integer ALU with valid/ready issue, ROB tag and flush.
// Revision   : 1.0 - initial release
// ============================================================================
module fu_alu_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] data_0,
    input  logic [DATA_WIDTH-1:0] data_1,
    input  logic [TAG_WIDTH-1:0]  tag,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [TAG_WIDTH-1:0]  result_tag,
    output logic                  idle
);

    localparam int         c_shamt_w = $clog2(DATA_WIDTH);
    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_and  = 4'd2;
    localparam logic [3:0] c_op_or   = 4'd3;
    localparam logic [3:0] c_op_xor  = 4'd4;
    localparam logic [3:0] c_op_sll  = 4'd5;
    localparam logic [3:0] c_op_srl  = 4'd6;
    localparam logic [3:0] c_op_sra  = 4'd7;
    localparam logic [3:0] c_op_slt  = 4'd8;
    localparam logic [3:0] c_op_sltu = 4'd9;

    logic [LATENCY-1:0]    valid_q;
    logic [DATA_WIDTH-1:0] result_q [LATENCY];
    logic [TAG_WIDTH-1:0]  tag_q    [LATENCY];
    logic [DATA_WIDTH-1:0] alu_d;
    logic [c_shamt_w-1:0]  w_shamt;
    logic                  w_advance;
    logic                  w_fire;

    assign w_shamt = data_1[c_shamt_w-1:0];

    always_comb begin
        alu_d = '0;
        case (op)
            c_op_add:  alu_d = data_0 + data_1;
            c_op_sub:  alu_d = data_0 - data_1;
            c_op_and:  alu_d = data_0 & data_1;
            c_op_or:   alu_d = data_0 | data_1;
            c_op_xor:  alu_d = data_0 ^ data_1;
            c_op_sll:  alu_d = data_0 << w_shamt;
            c_op_srl:  alu_d = data_0 >> w_shamt;
            c_op_sra:  alu_d = DATA_WIDTH'($signed(data_0) >>> w_shamt);
            c_op_slt:  alu_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(data_0) < $signed(data_1))};
            c_op_sltu: alu_d = {{(DATA_WIDTH-1){1'b0}}, (data_0 < data_1)};
            default:   alu_d = '0;
        endcase
    end

    // Whole-pipe stall: a blocked output freezes every stage, bubbles included.
    assign w_advance   = !valid_q[LATENCY-1] || result_ready;
    assign issue_ready = w_advance && !flush && !rst;
    assign w_fire      = issue_valid && issue_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                result_q[i] <= '0;
                tag_q[i]    <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (w_advance) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                valid_q[i]  <= valid_q[i-1];
                result_q[i] <= result_q[i-1];
                tag_q[i]    <= tag_q[i-1];
            end
            valid_q[0]  <= w_fire;
            result_q[0] <= alu_d;
            tag_q[0]    <= tag;
        end
    end

    assign result_valid = valid_q[LATENCY-1];
    assign result       = result_q[LATENCY-1];
    assign result_tag   = tag_q[LATENCY-1];
    assign idle         = !(|valid_q) && !issue_valid;

endmodule
`default_nettype wire

// File: tb/tb_fu_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module     : tb_fu_alu_pipe
// Description: Directed self-checking bench for LATENCY=1 and LATENCY=3 builds.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_fu_alu_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        issue_valid;
    logic [3:0]  op;
    logic [31:0] data_0;
    logic [31:0] data_1;
    logic [5:0]  tag;
    logic        result_ready;

    logic        ir1, rv1, idle1;
    logic [31:0] res1;
    logic [5:0]  rt1;
    logic        ir3, rv3, idle3;
    logic [31:0] res3;
    logic [5:0]  rt3;

    int n_chk;
    int n_err;

    fu_alu_pipe #(.DATA_WIDTH(32), .LATENCY(1), .TAG_WIDTH(6)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(ir1),
        .op(op), .data_0(data_0), .data_1(data_1), .tag(tag),
        .result_valid(rv1), .result_ready(result_ready),
        .result(res1), .result_tag(rt1), .idle(idle1)
    );

    fu_alu_pipe #(.DATA_WIDTH(32), .LATENCY(3), .TAG_WIDTH(6)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(ir3),
        .op(op), .data_0(data_0), .data_1(data_1), .tag(tag),
        .result_valid(rv3), .result_ready(result_ready),
        .result(res3), .result_tag(rt3), .idle(idle3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int c_nvec = 17;
    vec_t vecs [c_nvec];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        issue_valid = 1'b0;
        result_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int issued;
        int retired;
        logic [5:0] tg;

        n_chk = 0;
        n_err = 0;
        vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'd2,          32'h0000_0001};
        vecs[1]  = '{4'd1,  32'd3,         32'd5,          32'hFFFF_FFFE};
        vecs[2]  = '{4'd2,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F};
        vecs[3]  = '{4'd3,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
        vecs[4]  = '{4'd4,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
        vecs[5]  = '{4'd5,  32'h0000_0001, 32'd31,         32'h8000_0000};
        vecs[6]  = '{4'd5,  32'h0000_0001, 32'd33,         32'h0000_0002};
        vecs[7]  = '{4'd6,  32'h8000_0000, 32'd36,         32'h0800_0000};
        vecs[8]  = '{4'd7,  32'h8000_0000, 32'd4,          32'hF800_0000};
        vecs[9]  = '{4'd7,  32'h7FFF_FFFF, 32'd4,          32'h07FF_FFFF};
        vecs[10] = '{4'd8,  32'hFFFF_FFFF, 32'd1,          32'h0000_0001};
        vecs[11] = '{4'd8,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{4'd9,  32'hFFFF_FFFF, 32'd1,          32'h0000_0000};
        vecs[13] = '{4'd9,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[14] = '{4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000};
        vecs[15] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[16] = '{4'd0,  32'h7FFF_FFFF, 32'd1,          32'h8000_0000};

        rst = 1'b1;
        flush = 1'b0;
        issue_valid = 1'b0;
        op = 4'd0;
        data_0 = '0;
        data_1 = '0;
        tag = '0;
        result_ready = 1'b1;

        // Reset state, checked after each of two reset edges
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_rv1",   64'(rv1),   64'd0);
            chk("rst_res1",  64'(res1),  64'd0);
            chk("rst_tag1",  64'(rt1),   64'd0);
            chk("rst_idle1", 64'(idle1), 64'd1);
            chk("rst_ir1",   64'(ir1),   64'd0);
            chk("rst_rv3",   64'(rv3),   64'd0);
            chk("rst_res3",  64'(res3),  64'd0);
            chk("rst_tag3",  64'(rt3),   64'd0);
            chk("rst_idle3", 64'(idle3), 64'd1);
            chk("rst_ir3",   64'(ir3),   64'd0);
        end
        rst = 1'b0;

        // Single-op table on both builds
        for (int i = 0; i < c_nvec; i++) begin
            tick();
            tg = 6'(i + 5);
            issue_valid = 1'b1;
            op = vecs[i].op;
            data_0 = vecs[i].a;
            data_1 = vecs[i].b;
            tag = tg;
            result_ready = 1'b1;
            #1;
            chk($sformatf("v%0d_ir1", i), 64'(ir1), 64'd1);
            chk($sformatf("v%0d_ir3", i), 64'(ir3), 64'd1);
            tick();
            issue_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_rv1", i),    64'(rv1),   64'd1);
            chk($sformatf("v%0d_res1", i),   64'(res1),  64'(vecs[i].exp));
            chk($sformatf("v%0d_tag1", i),   64'(rt1),   64'(tg));
            chk($sformatf("v%0d_rv3_e", i),  64'(rv3),   64'd0);
            chk($sformatf("v%0d_idle3", i),  64'(idle3), 64'd0);
            tick();
            chk($sformatf("v%0d_idle1", i),  64'(idle1), 64'd1);
            chk($sformatf("v%0d_rv3_m", i),  64'(rv3),   64'd0);
            tick();
            chk($sformatf("v%0d_rv3", i),    64'(rv3),   64'd1);
            chk($sformatf("v%0d_res3", i),   64'(res3),  64'(vecs[i].exp));
            chk($sformatf("v%0d_tag3", i),   64'(rt3),   64'(tg));
            tick();
            chk($sformatf("v%0d_idle3_e", i), 64'(idle3), 64'd1);
        end

        // Streaming with backpressure on cycles 4..6 (LATENCY=3)
        do_reset();
        issued = 0;
        retired = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            issue_valid = (issued < 10);
            op = 4'd0;
            tag = 6'(issued);
            data_0 = 32'(issued);
            data_1 = 32'd100;
            result_ready = !(cyc >= 4 && cyc <= 6);
            #1;
            chk($sformatf("str_ir_c%0d", cyc), 64'(ir3), 64'(!(cyc >= 4 && cyc <= 6)));
            if (rv3 && result_ready) begin
                chk($sformatf("str_tag_c%0d", cyc), 64'(rt3),  64'(retired));
                chk($sformatf("str_res_c%0d", cyc), 64'(res3), 64'(retired + 100));
                if (retired == 9) chk("str_last_cycle", 64'(cyc), 64'd15);
                retired++;
            end
            if (issue_valid && ir3) issued++;
            if (retired == 10) break;
            tick();
        end
        if (retired != 10) chk("str_timeout_retired", 64'(retired), 64'd10);
        issue_valid = 1'b0;
        result_ready = 1'b1;

        // Full pipe, issue and retire every cycle
        do_reset();
        for (int cyc = 0; cyc < 23; cyc++) begin
            issue_valid = 1'b1;
            op = 4'd0;
            tag = 6'(cyc);
            data_0 = 32'(cyc);
            data_1 = 32'd1;
            result_ready = 1'b1;
            #1;
            chk($sformatf("full_ir_c%0d", cyc), 64'(ir3), 64'd1);
            if (cyc >= 3) begin
                chk($sformatf("full_rv_c%0d", cyc),  64'(rv3),  64'd1);
                chk($sformatf("full_tag_c%0d", cyc), 64'(rt3),  64'(cyc - 3));
                chk($sformatf("full_res_c%0d", cyc), 64'(res3), 64'(cyc - 2));
            end
            tick();
        end
        issue_valid = 1'b0;

        // Flush with three ops in flight and a concurrent issue
        do_reset();
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1'b1;
            op = 4'd0;
            tag = 6'(20 + k);
            data_0 = 32'(k);
            data_1 = 32'd0;
            tick();
        end
        issue_valid = 1'b1;
        tag = 6'd23;
        flush = 1'b1;
        #1;
        chk("fl_ir_in_flush", 64'(ir3), 64'd0);
        chk("fl_rv_in_flush", 64'(rv3), 64'd1);
        chk("fl_tag_in_flush", 64'(rt3), 64'd20);
        tick();
        flush = 1'b0;
        issue_valid = 1'b1;
        tag = 6'd30;
        data_0 = 32'd7;
        data_1 = 32'd8;
        #1;
        chk("fl_rv_after", 64'(rv3), 64'd0);
        chk("fl_ir_after", 64'(ir3), 64'd1);
        tick();
        issue_valid = 1'b0;
        for (int cyc = 5; cyc <= 10; cyc++) begin
            chk($sformatf("fl_rv_c%0d", cyc), 64'(rv3), 64'(cyc == 7));
            if (rv3) begin
                chk($sformatf("fl_tag_c%0d", cyc), 64'(rt3),  64'd30);
                chk($sformatf("fl_res_c%0d", cyc), 64'(res3), 64'd15);
            end
            tick();
        end

        // Reset while stalled on a valid result
        do_reset();
        issue_valid = 1'b1;
        op = 4'd0;
        tag = 6'd41;
        data_0 = 32'h0000_1234;
        data_1 = 32'h0000_0001;
        result_ready = 1'b0;
        tick();
        issue_valid = 1'b0;
        tick();
        tick();
        chk("mrst_rv_pre", 64'(rv3), 64'd1);
        chk("mrst_tag_pre", 64'(rt3), 64'd41);
        tick();
        chk("mrst_stalled", 64'(rv3), 64'd1);
        rst = 1'b1;
        #1;
        chk("mrst_ir", 64'(ir3), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_rv",   64'(rv3),   64'd0);
        chk("mrst_res",  64'(res3),  64'd0);
        chk("mrst_tag",  64'(rt3),   64'd0);
        chk("mrst_idle", 64'(idle3), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fu_alu_pipe.md
# fu_alu_pipe

Pipelined, parametrised integer ALU functional unit for the superscalar RISC-V back end. It replaces the single-operation, single-outstanding adder unit. It accepts one operation per cycle over a valid/ready issue port and carries a ROB tag alongside the data. Results appear after a fixed, parametrised latency. The unit supports output backpressure and a pipeline flush for branch mispredict recovery. It sits between the reservation station issue logic and the common data bus arbiter.

## Interface
- DATA_WIDTH, 32, operand/result width; power of two, ≥ 8
- LATENCY, 1, pipeline depth in cycles from issue to result; ≥ 1
- TAG_WIDTH, 6, ROB tag width

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all in-flight operations
- issue_valid  input  1  issue request
- issue_ready  output  1  unit can accept this cycle
- op  input  4  operation select (encoding below)
- data_0, data_1  input  DATA_WIDTH  operands
- tag  input  TAG_WIDTH  ROB tag of the issued operation
- result_valid  output  1  result/tag valid
- result_ready  input  1  CDB arbiter accepts result
- result  output  DATA_WIDTH  operation result
- result_tag  output  TAG_WIDTH  tag of the presented result
- idle  output  1  no operation in flight and none being issued

## Operation
- op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 1/0), 9 SLTU (unsigned, result 1/0). Codes 10–15 produce result 0 with a valid tag; they are not errors.
- Arithmetic is modulo 2^DATA_WIDTH and carry is discarded. The shift amount is data_1[$clog2(DATA_WIDTH)-1:0]; upper bits are ignored.
- The result is computed combinationally from the issue inputs and captured into stage 1. Stages 1..LATENCY each hold {valid, result, tag}, and stage LATENCY drives the outputs.
- Handshake: an issue occurs when issue_valid && issue_ready; a retire occurs when result_valid && result_ready.
- advance = !result_valid || result_ready.
- When advance is high, all stages shift by one and stage 1 loads the issue (valid = issue fire).
- When advance is low, every stage holds (whole-pipe stall, no bubble collapse).
- issue_ready = advance && !flush && !rst.
- flush: at the next edge every stage's valid bit is cleared and any concurrent issue is dropped. Data and tag registers may keep stale values.
- flush takes priority over advance and issue. rst takes priority over everything.
- idle = no stage valid && !issue_valid.
- Inputs are don't-care when issue_valid is low, and outputs other than result_valid are don't-care when result_valid is low. In all cases no X may propagate into the valid bits.

## Timing
- Reset, asserted at an edge: all valid bits = 0, all result/tag registers = 0. During and after reset: result_valid = 0, result = 0, result_tag = 0, idle = 1 (issue_valid low), issue_ready = 0 while rst is high.
- Latency: an issue in cycle c with no stall gives result_valid high in cycle c + LATENCY.
- Throughput is one operation per cycle. Back-to-back issues retire in order on consecutive cycles when result_ready is held high.
- A stall of S cycles at the output delays every in-flight result by exactly S cycles. No result is lost or duplicated, and results stay in order.
- Issue and retire may occur in the same cycle (pipe full, result_ready = 1). Both happen, so a full pipe sustains one op per cycle.
- Flush in cycle f: result_valid = 0 in cycle f+1 regardless of result_ready. A result presented in cycle f with result_ready = 1 counts as retired; a flushed-away result does not.
- Reset mid-operation behaves like flush and also zeroes data/tag registers. Issue is refused in the reset cycle.
- LATENCY = 1: stage 1 is the output stage, so issue_ready depends combinationally on result_ready.

## Test plan
- Reset then single ADD: rst for 2 cycles, then issue ADD 0xFFFFFFFF + 2, tag 5 → result_valid exactly LATENCY cycles later with result 0x00000001, result_tag 5; idle returns to 1 the next cycle.
- All opcodes: SUB 3−5 = 0xFFFFFFFE; SRA 0x80000000 by 4 = 0xF8000000; SRL by 36 (shift amount 4) = 0x08000000; SLT(−1, 1) = 1; SLTU(−1, 1) = 0; op 12 → 0. Check every case in both LATENCY = 1 and LATENCY = 3 builds.
- Streaming with backpressure, LATENCY = 3: issue tags 0..9 on consecutive cycles and toggle result_ready low for cycles 4–6 → tags 0..9 retire in order with no loss, issue_ready low exactly while stalled, and total time = 10 + 3 + 3 cycles.
- Full pipe, simultaneous issue/retire: keep the pipe full with result_ready = 1 → one retire and one issue per cycle for 20 cycles.
- Flush: with 3 ops in flight and issue_valid high in the flush cycle → result_valid = 0 the next cycle, no flushed tag ever appears, and the next issue returns its result after LATENCY cycles.
- Reset mid-stream: assert rst while stalled with a valid result → the next cycle has result_valid = 0, result = 0, result_tag = 0, idle = 1.
